// File: rtl/uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_feeder: byte FIFO + dispatch FSM feeding a UART TX serializer.     |
// | Optional occupancy port: define UART_TX_FEEDER_LEVEL_EN for level_out.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  wr_en_in,
   input  logic [DATA_WIDTH-1:0] wr_data_in,
   output logic                  full_out,
   output logic                  empty_out,
   output logic                  overflow_out,
   output logic                  tx_en_out,
   output logic [DATA_WIDTH-1:0] txdata_out,
   input  logic                  tx_done_in,
   output logic                  busy_out
`ifdef UART_TX_FEEDER_LEVEL_EN
   ,
   output logic [ADDR_WIDTH:0]   level_out
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_STROBE    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic                  w_push;
   logic                  w_pop;

   // Both decisions use the registered flags, so a same-edge pop never frees
   // room for a push and a fresh byte cannot bypass straight to the serializer.
   assign w_push = wr_en_in && !full_out;
   assign w_pop  = (r_state == ST_IDLE) && !empty_out && tx_done_in;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
         2'b01:   w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         full_out     <= 1'b0;
         empty_out    <= 1'b1;
         overflow_out <= 1'b0;
         txdata_out   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
            txdata_out <= r_mem[r_rd_ptr];
         end
         r_count      <= w_count_nxt;
         full_out     <= (w_count_nxt == c_FULL_COUNT);
         empty_out    <= (w_count_nxt == '0);
         overflow_out <= wr_en_in && full_out;
      end
   end

`ifdef UART_TX_FEEDER_LEVEL_EN
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         level_out <= '0;
      end else begin
         level_out <= w_count_nxt;
      end
   end
`else
   // Occupancy stays internal in r_count when the level port is not built.
`endif

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Serializer handshake: one-cycle strobe, then see done fall and rise again.
   always_comb begin
      w_state_nxt = r_state;
      tx_en_out   = 1'b0;
      busy_out    = (r_state != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_pop) begin
               w_state_nxt = ST_STROBE;
            end
         end
         ST_STROBE: begin
            tx_en_out   = 1'b1;
            w_state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!tx_done_in) begin
               w_state_nxt = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done_in) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_feeder: randomized self-checking bench with queue-based model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_feeder;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk_in;
   logic          rst_in;
   logic          wr_en_in;
   logic [DW-1:0] wr_data_in;
   logic          full_out;
   logic          empty_out;
   logic          overflow_out;
   logic          tx_en_out;
   logic [DW-1:0] txdata_out;
   logic          tx_done_in;
   logic          busy_out;
`ifdef UART_TX_FEEDER_LEVEL_EN
   logic [AW:0]   level_out;
`endif

   uart_tx_feeder #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .wr_en_in     (wr_en_in),
      .wr_data_in   (wr_data_in),
      .full_out     (full_out),
      .empty_out    (empty_out),
      .overflow_out (overflow_out),
      .tx_en_out    (tx_en_out),
      .txdata_out   (txdata_out),
      .tx_done_in   (tx_done_in),
      .busy_out     (busy_out)
`ifdef UART_TX_FEEDER_LEVEL_EN
      ,
      .level_out    (level_out)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: queue contents, handshake phase (0 idle, 1 strobing,
   // 2 awaiting done low, 3 awaiting done high), last dispatched byte.
   logic [DW-1:0] m_q[$];
   int            m_phase;
   logic [DW-1:0] m_txdata;
   logic          m_ovf;
   logic [DW-1:0] exp_sent[$];
   logic [DW-1:0] act_sent[$];

   // Serializer stand-in
   logic ser_done;
   logic hold_low;
   int   ser_drop;
   int   ser_low;
   int   drop_lat;
   int   low_len;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_phase  = 0;
      m_txdata = '0;
      m_ovf    = 1'b0;
   endtask

   task automatic model_edge(input logic wr, input logic [DW-1:0] d, input logic done);
      int   sz;
      logic full_seen;
      logic pop;
      sz        = m_q.size();
      full_seen = (sz == DEPTH);
      pop       = (m_phase == 0) && (sz != 0) && done;
      m_ovf     = wr && full_seen;
      case (m_phase)
         0: if (pop) m_phase = 1;
         1: m_phase = 2;
         2: if (!done) m_phase = 3;
         default: if (done) m_phase = 0;
      endcase
      if (pop) begin
         m_txdata = m_q.pop_front();
         exp_sent.push_back(m_txdata);
      end
      if (wr && !full_seen) m_q.push_back(d);
   endtask

   task automatic compare_outputs();
      check_val("full",   full_out,     m_q.size() == DEPTH);
      check_val("empty",  empty_out,    m_q.size() == 0);
      check_val("ovf",    overflow_out, m_ovf);
      check_val("tx_en",  tx_en_out,    m_phase == 1);
      check_val("txdata", txdata_out,   m_txdata);
      check_val("busy",   busy_out,     m_phase != 0);
`ifdef UART_TX_FEEDER_LEVEL_EN
      check_val("level",  level_out,    m_q.size());
`endif
   endtask

   task automatic cycle(input logic wr, input logic [DW-1:0] d);
      wr_en_in   = wr;
      wr_data_in = d;
      tx_done_in = ser_done & ~hold_low;
      @(posedge clk_in);
      model_edge(wr, d, tx_done_in);
      #1;
      compare_outputs();
      if (tx_en_out) act_sent.push_back(txdata_out);
      if (tx_en_out) begin
         ser_drop = drop_lat;
      end else if (ser_drop > 0) begin
         ser_drop--;
         if (ser_drop == 0) begin
            ser_done = 1'b0;
            ser_low  = low_len;
         end
      end else if (ser_low > 0) begin
         ser_low--;
         if (ser_low == 0) ser_done = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(m_q.size() == 0 && m_phase == 0 && ser_drop == 0 && ser_low == 0 && ser_done)
             && n < budget) begin
         cycle(1'b0, '0);
         n++;
      end
      check_val("drain_timeout", n >= budget, 0);
      check_val("drain_busy", busy_out, 0);
   endtask

   task automatic compare_logs();
      int n;
      check_val("sent_count", act_sent.size(), exp_sent.size());
      n = (act_sent.size() < exp_sent.size()) ? act_sent.size() : exp_sent.size();
      for (int i = 0; i < n; i++) check_val("sent_byte", act_sent[i], exp_sent[i]);
      act_sent.delete();
      exp_sent.delete();
   endtask

   initial begin
      logic [DW-1:0] bytes[$];
      int            n;

      rst_in     = 1'b0;
      wr_en_in   = 1'b0;
      wr_data_in = '0;
      tx_done_in = 1'b1;
      ser_done   = 1'b1;
      hold_low   = 1'b0;
      ser_drop   = 0;
      ser_low    = 0;
      drop_lat   = 1;
      low_len    = 20;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk_in);
      #1;
      check_val("rst_empty", empty_out, 1);
      check_val("rst_full",  full_out,  0);
      check_val("rst_tx_en", tx_en_out, 0);
      check_val("rst_busy",  busy_out,  0);
      rst_in = 1'b1;

      // Idle with no pushes
      for (int i = 0; i < 100; i++) cycle(1'b0, '0);
      check_val("idle_no_strobe", act_sent.size(), 0);

      // Single byte, one-cycle latency
      cycle(1'b1, 8'hA5);
      cycle(1'b0, '0);
      check_val("a5_strobe", tx_en_out,  1);
      check_val("a5_data",   txdata_out, 8'hA5);
      check_val("a5_busy",   busy_out,   1);
      wait_idle(200);
      compare_logs();

      // Three consecutive bytes, long serializer frame
      cycle(1'b1, 8'h11);
      cycle(1'b1, 8'h22);
      cycle(1'b1, 8'h33);
      wait_idle(300);
      check_val("seq_count", act_sent.size(), 3);
      if (act_sent.size() == 3) begin
         check_val("seq_b0", act_sent[0], 8'h11);
         check_val("seq_b1", act_sent[1], 8'h22);
         check_val("seq_b2", act_sent[2], 8'h33);
      end
      compare_logs();

      // Overflow while serializer is held busy
      hold_low = 1'b1;
      bytes.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
         bytes.push_back(DW'($urandom));
         cycle(1'b1, bytes[i]);
         if (i == DEPTH - 1) check_val("ovf_full16", full_out, 1);
         if (i == DEPTH)     check_val("ovf_pulse",  overflow_out, 1);
      end
      cycle(1'b0, '0);
      check_val("ovf_one_cycle", overflow_out, 0);
      hold_low = 1'b0;
      wait_idle(1000);
      check_val("ovf_sent_count", act_sent.size(), DEPTH);
      n = (act_sent.size() < DEPTH) ? act_sent.size() : DEPTH;
      for (int i = 0; i < n; i++) check_val("ovf_sent_byte", act_sent[i], bytes[i]);
      compare_logs();

      // Full FIFO: push and pop on the same edge
      hold_low = 1'b1;
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom));
      check_val("pp_full", full_out, 1);
      hold_low = 1'b0;
      cycle(1'b1, 8'h5A);
      check_val("pp_ovf",   overflow_out, 1);
      check_val("pp_full2", full_out,     0);
      check_val("pp_strobe", tx_en_out,   1);
`ifdef UART_TX_FEEDER_LEVEL_EN
      check_val("pp_level", level_out, DEPTH - 1);
`endif
      wait_idle(1000);
      compare_logs();

      // Asynchronous reset in WAIT_DONE with 5 bytes queued
      drop_lat = 1;
      low_len  = 20;
      for (int i = 0; i < 6; i++) cycle(1'b1, DW'($urandom));
      n = 0;
      while (!(m_phase == 3 && m_q.size() == 5) && n < 50) begin
         cycle(1'b0, '0);
         n++;
      end
      check_val("rst_reach_wait", n >= 50, 0);
      compare_logs();
      #2 rst_in = 1'b0;
      #1;
      check_val("arst_full",   full_out,     0);
      check_val("arst_empty",  empty_out,    1);
      check_val("arst_ovf",    overflow_out, 0);
      check_val("arst_tx_en",  tx_en_out,    0);
      check_val("arst_txdata", txdata_out,   0);
      check_val("arst_busy",   busy_out,     0);
      model_reset();
      #2 rst_in = 1'b1;
      for (int i = 0; i < 40; i++) cycle(1'b0, '0);
      check_val("arst_no_strobe", act_sent.size(), 0);
      cycle(1'b1, 8'h3C);
      wait_idle(200);
      check_val("arst_new_count", act_sent.size(), 1);
      if (act_sent.size() == 1) check_val("arst_new_byte", act_sent[0], 8'h3C);
      compare_logs();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            drop_lat = $urandom_range(1, 3);
            low_len  = $urandom_range(1, 10);
         end
         if ($urandom_range(0, 59) == 0) hold_low = ~hold_low;
         cycle($urandom_range(0, 2) == 0, DW'($urandom));
      end
      hold_low = 1'b0;
      wait_idle(2000);
      compare_logs();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
